axi_lite_read_capture: RTL and testbench

Parametrised AXI4-Lite read-channel monitor/capture block. It accepts AR and R beats independently, each on its own handshake, and buffers each in its own FIFO. It pairs them in order and presents {addr, data, resp} on a valid/ready output stream to external logic. Replaces single-entry, no-backpressure capture with configurable widths, depth and response forwarding.

---
 rtl/axi_rd_pkg.sv | 17 +
 rtl/axi_rd_fifo.sv | 58 +++++
 rtl/axi_lite_read_capture.sv | 104 ++++++++++
 tb/tb_axi_lite_read_capture.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// Shared AXI4-Lite read-channel definitions: response encodings and helpers
// used by the read capture block and its FIFOs.
package axi_rd_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    // SLVERR and DECERR both carry bit 1 set.
    function automatic logic resp_is_err(input resp_t resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi_rd_fifo.sv
// Generic first-word-fall-through FIFO; the head entry is visible on dout
// whenever the FIFO is not empty, and dout reads zero while empty.
module axi_rd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LVL_FULL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage is payload only, so it carries no reset.
    always_ff @(posedge ACLK) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/axi_lite_read_capture.sv
// AXI4-Lite read-channel capture: queues AR and R beats independently and
// emits in-order {addr, data, resp} pairs. Optional AXI_RD_STATS_EN adds counters.
module axi_lite_read_capture
    import axi_rd_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic [ADDR_W-1:0]          ARADDR,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    input  logic [DATA_W-1:0]          RDATA,
    input  logic [1:0]                 RRESP,
    input  logic                       RVALID,
    output logic                       RREADY,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [DATA_W-1:0]          out_data,
    output logic [1:0]                 out_resp,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] addr_level,
    output logic [$clog2(DEPTH+1)-1:0] data_level
`ifdef AXI_RD_STATS_EN
    ,
    output logic [31:0]                txn_count,
    output logic [15:0]                err_count
`endif
);

    logic              run_q;
    logic              addr_full;
    logic              addr_empty;
    logic              data_full;
    logic              data_empty;
    logic              ar_push;
    logic              r_push;
    logic              pair_pop;
    logic [DATA_W+1:0] r_entry;
    logic [DATA_W+1:0] r_head;

    // Holds both ready outputs low through reset and for no longer than the
    // first edge after release.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) run_q <= 1'b0;
        else          run_q <= 1'b1;
    end

    assign ARREADY   = run_q & ~addr_full;
    assign RREADY    = run_q & ~data_full;
    assign ar_push   = ARVALID & ARREADY;
    assign r_push    = RVALID & RREADY;
    assign out_valid = ~addr_empty & ~data_empty;
    assign pair_pop  = out_valid & out_ready;
    assign r_entry   = {RRESP, RDATA};

    axi_rd_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_addr_fifo (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .push    (ar_push),
        .pop     (pair_pop),
        .din     (ARADDR),
        .dout    (out_addr),
        .full    (addr_full),
        .empty   (addr_empty),
        .level   (addr_level)
    );

    axi_rd_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .push    (r_push),
        .pop     (pair_pop),
        .din     (r_entry),
        .dout    (r_head),
        .full    (data_full),
        .empty   (data_empty),
        .level   (data_level)
    );

    assign out_data = r_head[DATA_W-1:0];
    assign out_resp = r_head[DATA_W+1:DATA_W];

`ifdef AXI_RD_STATS_EN
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            txn_count <= '0;
            err_count <= '0;
        end else if (pair_pop) begin
            txn_count <= txn_count + 32'd1;
            if (resp_is_err(out_resp)) err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_lite_read_capture.sv
// Directed bench for axi_lite_read_capture; stats checks compile only with AXI_RD_STATS_EN.
module tb_axi_lite_read_capture;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int LVL_W  = $clog2(DEPTH+1);

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_resp;
    logic              out_valid;
    logic              out_ready;
    logic [LVL_W-1:0]  addr_level;
    logic [LVL_W-1:0]  data_level;
`ifdef AXI_RD_STATS_EN
    logic [31:0]       txn_count;
    logic [15:0]       err_count;
`endif

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] a_exp [100];
    logic [DATA_W-1:0] d_exp [100];

    always #5 ACLK = ~ACLK;

    axi_lite_read_capture #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .ARADDR     (ARADDR),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .RDATA      (RDATA),
        .RRESP      (RRESP),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_resp   (out_resp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .addr_level (addr_level),
        .data_level (data_level)
`ifdef AXI_RD_STATS_EN
        ,
        .txn_count  (txn_count),
        .err_count  (err_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        ARVALID   = 1'b0;
        RVALID    = 1'b0;
        out_ready = 1'b0;
        ARADDR    = '0;
        RDATA     = '0;
        RRESP     = '0;

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_arready", 64'(ARREADY), 64'd0);
        chk("rst_rready", 64'(RREADY), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_addr_level", 64'(addr_level), 64'd0);
        chk("rst_data_level", 64'(data_level), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        ARESETn = 1'b1;
        chk("rel_arready_pre", 64'(ARREADY), 64'd0);
        tick();
        chk("rel_arready", 64'(ARREADY), 64'd1);
        chk("rel_rready", 64'(RREADY), 64'd1);

        // Single read: AR first, R two cycles later
        out_ready = 1'b1;
        ARVALID = 1'b1;
        ARADDR  = 8'h10;
        tick();
        ARVALID = 1'b0;
        chk("sr_addr_level", 64'(addr_level), 64'd1);
        chk("sr_valid_wait", 64'(out_valid), 64'd0);
        tick();
        RVALID = 1'b1;
        RDATA  = 32'hDEADBEEF;
        RRESP  = 2'b00;
        chk("sr_valid_wait2", 64'(out_valid), 64'd0);
        tick();
        RVALID = 1'b0;
        chk("sr_valid", 64'(out_valid), 64'd1);
        chk("sr_addr", 64'(out_addr), 64'h10);
        chk("sr_data", 64'(out_data), 64'hDEADBEEF);
        chk("sr_resp", 64'(out_resp), 64'd0);
        tick();
        chk("sr_valid_done", 64'(out_valid), 64'd0);
        chk("sr_levels", 64'({addr_level, data_level}), 64'd0);

        // Address leads until full, then data drains it
        for (int i = 0; i < 4; i++) begin
            ARVALID = 1'b1;
            ARADDR  = 8'(4 * i);
            tick();
        end
        ARVALID = 1'b0;
        chk("al_arready_full", 64'(ARREADY), 64'd0);
        chk("al_addr_level", 64'(addr_level), 64'd4);
        chk("al_out_valid", 64'(out_valid), 64'd0);
        RVALID = 1'b1;
        RDATA  = 32'hA0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("al_pair_valid", 64'(out_valid), 64'd1);
            chk("al_pair_addr", 64'(out_addr), 64'(4 * i));
            chk("al_pair_data", 64'(out_data), 64'(32'hA0 + 32'(i)));
            chk("al_addr_level_i", 64'(addr_level), 64'(4 - i));
            if (i < 3) RDATA = 32'hA0 + 32'(i + 1);
            else       RVALID = 1'b0;
        end
        tick();
        chk("al_done_valid", 64'(out_valid), 64'd0);
        chk("al_done_levels", 64'({addr_level, data_level}), 64'd0);
        chk("al_done_arready", 64'(ARREADY), 64'd1);

        // Data leads with backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            RVALID = 1'b1;
            RDATA  = 32'hB0 + 32'(i);
            RRESP  = 2'(i);
            tick();
        end
        RVALID = 1'b0;
        chk("dl_rready_full", 64'(RREADY), 64'd0);
        chk("dl_data_level", 64'(data_level), 64'd4);
        chk("dl_out_valid0", 64'(out_valid), 64'd0);
        ARVALID = 1'b1;
        ARADDR  = 8'h20;
        tick();
        ARADDR  = 8'h24;
        chk("dl_valid", 64'(out_valid), 64'd1);
        chk("dl_addr0", 64'(out_addr), 64'h20);
        chk("dl_data0", 64'(out_data), 64'hB0);
        chk("dl_resp0", 64'(out_resp), 64'd0);
        tick();
        ARVALID = 1'b0;
        repeat (2) begin
            tick();
            chk("dl_hold_addr", 64'(out_addr), 64'h20);
            chk("dl_hold_data", 64'(out_data), 64'hB0);
            chk("dl_hold_level", 64'(data_level), 64'd4);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("dl_addr1", 64'(out_addr), 64'h24);
        chk("dl_data1", 64'(out_data), 64'hB1);
        chk("dl_resp1", 64'(out_resp), 64'd1);
        chk("dl_level3", 64'(data_level), 64'd3);
        tick();
        chk("dl_hold1", 64'(out_addr), 64'h24);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("dl_valid_off", 64'(out_valid), 64'd0);
        chk("dl_level2", 64'(data_level), 64'd2);
        chk("dl_addr_level0", 64'(addr_level), 64'd0);
        chk("dl_rready_back", 64'(RREADY), 64'd1);
        out_ready = 1'b1;
        ARVALID = 1'b1;
        ARADDR  = 8'h28;
        tick();
        ARADDR  = 8'h2C;
        chk("dl_addr2", 64'(out_addr), 64'h28);
        chk("dl_data2", 64'(out_data), 64'hB2);
        chk("dl_resp2", 64'(out_resp), 64'd2);
        tick();
        ARVALID = 1'b0;
        chk("dl_addr3", 64'(out_addr), 64'h2C);
        chk("dl_data3", 64'(out_data), 64'hB3);
        chk("dl_resp3", 64'(out_resp), 64'd3);
        tick();
        chk("dl_drained", 64'({out_valid, data_level}), 64'd0);

        // Streaming at full rate against a stored reference
        for (int i = 0; i < 100; i++) begin
            a_exp[i] = 8'($urandom);
            d_exp[i] = $urandom;
        end
        out_ready = 1'b1;
        RRESP = 2'b00;
        for (int i = 0; i < 100; i++) begin
            ARVALID = 1'b1;
            RVALID  = 1'b1;
            ARADDR  = a_exp[i];
            RDATA   = d_exp[i];
            tick();
            chk("st_ready", 64'({ARREADY, RREADY, out_valid}), 64'h7);
            chk("st_levels", 64'({addr_level, data_level}), 64'({3'd1, 3'd1}));
            chk("st_addr", 64'(out_addr), 64'(a_exp[i]));
            chk("st_data", 64'(out_data), 64'(d_exp[i]));
        end
        ARVALID = 1'b0;
        RVALID  = 1'b0;
        tick();
        chk("st_drained", 64'({out_valid, addr_level, data_level}), 64'd0);

        // Reset asserted with entries queued
        out_ready = 1'b0;
        ARVALID = 1'b1;
        ARADDR  = 8'h55;
        RVALID  = 1'b1;
        RDATA   = 32'h1234;
        tick();
        tick();
        ARVALID = 1'b0;
        RVALID  = 1'b0;
        chk("mr_pre_valid", 64'(out_valid), 64'd1);
        #2;
        ARESETn = 1'b0;
        #1;
        chk("mr_arready", 64'(ARREADY), 64'd0);
        chk("mr_rready", 64'(RREADY), 64'd0);
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_levels", 64'({addr_level, data_level}), 64'd0);
        chk("mr_payload", 64'({out_addr, out_data}), 64'd0);
        tick();
        ARESETn = 1'b1;
        tick();
        chk("mr_rel_ready", 64'({ARREADY, RREADY}), 64'h3);
        chk("mr_rel_empty", 64'({out_valid, addr_level, data_level}), 64'd0);

`ifdef AXI_RD_STATS_EN
        // Counters: ten pairs, error responses on beats 3 and 7
        chk("stats_txn_rst", 64'(txn_count), 64'd0);
        chk("stats_err_rst", 64'(err_count), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ARVALID = 1'b1;
            RVALID  = 1'b1;
            ARADDR  = 8'(i);
            RDATA   = 32'(i);
            RRESP   = (i == 3 || i == 7) ? 2'b10 : 2'b00;
            tick();
        end
        ARVALID = 1'b0;
        RVALID  = 1'b0;
        tick();
        tick();
        chk("stats_txn", 64'(txn_count), 64'd10);
        chk("stats_err", 64'(err_count), 64'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
